boot_sequencer: RTL and testbench

//  Parametrised power-on boot sequencer and successor to the fixed 4-state boot FSM.

---
 rtl/boot_pkg.sv | 26 ++
 rtl/boot_sequencer_if.sv | 28 ++
 rtl/boot_dwell_counter.sv | 38 +++
 rtl/boot_sequencer.sv | 123 ++++++++++++
 tb/tb_boot_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_pkg.sv
// Shared constants and helpers for the parametrised boot sequencer.
// State codes are numeric (OFF=0, NORMAL=NUM_STAGES-1); the phase enum classifies a code.
package boot_pkg;

  localparam int unsigned BS_OFF       = 0;
  localparam int unsigned BOOT_COUNT_W = 8;

  typedef enum logic [1:0] {
    PH_OFF,
    PH_STAGE,
    PH_NORMAL,
    PH_INVALID
  } phase_e;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int normal_code(input int num_stages);
    return num_stages - 1;
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// Control/status bundle of the boot sequencer.
// The master (system controller) drives the requests; the slave (sequencer) reports status.
interface boot_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int ST_W       = 2
);

  logic                  enable;
  logic                  stall;
  logic                  stage_ack;
  logic                  soft_rst;
  logic [ST_W-1:0]       state;
  logic [NUM_STAGES-1:0] stage_onehot;
  logic                  normal;
  logic                  boot_done;
  logic [7:0]            boot_count;

  modport master (
    output enable, stall, stage_ack, soft_rst,
    input  state, stage_onehot, normal, boot_done, boot_count
  );

  modport slave (
    input  enable, stall, stage_ack, soft_rst,
    output state, stage_onehot, normal, boot_done, boot_count
  );

endinterface

// File: rtl/boot_dwell_counter.sv
// Dwell counter for one intermediate boot stage: clears on request, counts enabled cycles
// and saturates at HOLD_CYC-1 so it holds there while an acknowledge is awaited.
module boot_dwell_counter #(
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/boot_sequencer.sv
// Parametrised power-on boot sequencer: OFF -> stages 1..NUM_STAGES-2 -> sticky NORMAL,
// with enable gate, stall, optional per-stage acknowledge, soft reboot and a saturating boot count.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int HOLD_CYC   = 1,
  parameter int ACK_MODE   = 0,
  parameter int CNT_W      = 8,
  parameter int ST_W       = 2
) (
  input logic              clk,
  input logic              rst_n,
  boot_sequencer_if.slave  ctrl_if
);

  localparam logic [ST_W-1:0] OFF_CODE    = ST_W'(BS_OFF);
  localparam logic [ST_W-1:0] NORMAL_CODE = ST_W'(normal_code(NUM_STAGES));

  logic [ST_W-1:0]         state_q;
  logic [ST_W-1:0]         state_d;
  logic                    boot_done_q;
  logic                    boot_done_d;
  logic [BOOT_COUNT_W-1:0] boot_count_q;
  logic [BOOT_COUNT_W-1:0] boot_count_d;
  logic [NUM_STAGES-1:0]   onehot;
  phase_e                  phase;
  logic                    dwell_clr;
  logic                    dwell_inc;
  logic                    dwell_expired;

  boot_dwell_counter #(
    .CNT_W    (CNT_W),
    .HOLD_CYC (HOLD_CYC)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (dwell_clr),
    .inc_en_i  (dwell_inc),
    .expired_o (dwell_expired)
  );

  always_comb begin
    if (state_q == OFF_CODE) begin
      phase = PH_OFF;
    end else if (state_q == NORMAL_CODE) begin
      phase = PH_NORMAL;
    end else if (state_q < NORMAL_CODE) begin
      phase = PH_STAGE;
    end else begin
      phase = PH_INVALID;
    end
  end

  // The dwell counter is held clear everywhere except while sitting in a stage.
  always_comb begin
    state_d   = state_q;
    dwell_clr = 1'b1;
    dwell_inc = 1'b0;
    if (ctrl_if.soft_rst) begin
      state_d = OFF_CODE;
    end else begin
      case (phase)
        PH_OFF: begin
          if (ctrl_if.enable) state_d = state_q + 1'b1;
        end
        PH_STAGE: begin
          dwell_clr = 1'b0;
          if (!ctrl_if.stall) begin
            dwell_inc = 1'b1;
            if (dwell_expired && ((ACK_MODE == 0) || ctrl_if.stage_ack)) begin
              state_d   = state_q + 1'b1;
              dwell_clr = 1'b1;
            end
          end
        end
        PH_NORMAL: begin
          state_d = state_q;
        end
        default: begin
          state_d = OFF_CODE;
        end
      endcase
    end
  end

  always_comb begin
    boot_done_d  = 1'b0;
    boot_count_d = boot_count_q;
    if ((state_d == NORMAL_CODE) && (state_q != NORMAL_CODE)) begin
      boot_done_d = 1'b1;
      if (boot_count_q != {BOOT_COUNT_W{1'b1}}) begin
        boot_count_d = boot_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OFF_CODE;
      boot_done_q  <= 1'b0;
      boot_count_q <= '0;
    end else begin
      state_q      <= state_d;
      boot_done_q  <= boot_done_d;
      boot_count_q <= boot_count_d;
    end
  end

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      onehot[k] = (state_q == ST_W'(k));
    end
  end

  assign ctrl_if.state        = state_q;
  assign ctrl_if.stage_onehot = onehot;
  assign ctrl_if.normal       = (state_q == NORMAL_CODE);
  assign ctrl_if.boot_done    = boot_done_q;
  assign ctrl_if.boot_count   = boot_count_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench: three sequencer configurations (defaults, 5 stages x 3 cycles, ack mode)
// driven by directed scenarios and random traffic, compared against a cycle-level behavioural model.
module tb_boot_sequencer;

  localparam int N_DUT = 3;
  localparam int CFG_NS   [N_DUT] = '{4, 5, 4};
  localparam int CFG_HOLD [N_DUT] = '{1, 3, 2};
  localparam int CFG_ACK  [N_DUT] = '{0, 0, 1};

  typedef struct packed {
    int st;
    int dwell;
    bit done;
    int count;
  } model_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic drvEn    [N_DUT];
  logic drvStall [N_DUT];
  logic drvAck   [N_DUT];
  logic drvSrst  [N_DUT];

  int          obsState  [N_DUT];
  logic [31:0] obsOnehot [N_DUT];
  logic        obsNormal [N_DUT];
  logic        obsDone   [N_DUT];
  int          obsCount  [N_DUT];

  model_t mdl [N_DUT];
  int checks = 0;
  int errors = 0;

  boot_sequencer_if #(.NUM_STAGES(4), .ST_W(2)) ifA ();
  boot_sequencer_if #(.NUM_STAGES(5), .ST_W(3)) ifB ();
  boot_sequencer_if #(.NUM_STAGES(4), .ST_W(2)) ifC ();

  assign ifA.enable    = drvEn[0];
  assign ifA.stall     = drvStall[0];
  assign ifA.stage_ack = drvAck[0];
  assign ifA.soft_rst  = drvSrst[0];
  assign ifB.enable    = drvEn[1];
  assign ifB.stall     = drvStall[1];
  assign ifB.stage_ack = drvAck[1];
  assign ifB.soft_rst  = drvSrst[1];
  assign ifC.enable    = drvEn[2];
  assign ifC.stall     = drvStall[2];
  assign ifC.stage_ack = drvAck[2];
  assign ifC.soft_rst  = drvSrst[2];

  boot_sequencer #(.NUM_STAGES(4), .HOLD_CYC(1), .ACK_MODE(0), .CNT_W(8), .ST_W(2)) dutA (
    .clk(clk), .rst_n(rst_n), .ctrl_if(ifA));
  boot_sequencer #(.NUM_STAGES(5), .HOLD_CYC(3), .ACK_MODE(0), .CNT_W(8), .ST_W(3)) dutB (
    .clk(clk), .rst_n(rst_n), .ctrl_if(ifB));
  boot_sequencer #(.NUM_STAGES(4), .HOLD_CYC(2), .ACK_MODE(1), .CNT_W(8), .ST_W(2)) dutC (
    .clk(clk), .rst_n(rst_n), .ctrl_if(ifC));

  always_comb begin
    obsState[0]  = int'(ifA.state);
    obsState[1]  = int'(ifB.state);
    obsState[2]  = int'(ifC.state);
    obsOnehot[0] = 32'(ifA.stage_onehot);
    obsOnehot[1] = 32'(ifB.stage_onehot);
    obsOnehot[2] = 32'(ifC.stage_onehot);
    obsNormal[0] = ifA.normal;
    obsNormal[1] = ifB.normal;
    obsNormal[2] = ifC.normal;
    obsDone[0]   = ifA.boot_done;
    obsDone[1]   = ifB.boot_done;
    obsDone[2]   = ifC.boot_done;
    obsCount[0]  = int'(ifA.boot_count);
    obsCount[1]  = int'(ifB.boot_count);
    obsCount[2]  = int'(ifC.boot_count);
  end

  // Reference model: a stage is left once it has seen HOLD_CYC unstalled cycles
  // (and, in ack mode, an ack on an unstalled cycle at or after that point).
  function automatic model_t model_next(input model_t m, input int idx, input bit en,
                                        input bit stall, input bit ack, input bit srst);
    model_t n;
    int     last;
    n      = m;
    n.done = 1'b0;
    last   = CFG_NS[idx] - 1;
    if (srst) begin
      n.st    = 0;
      n.dwell = 0;
      return n;
    end
    if (m.st == 0) begin
      if (en) n.st = 1;
      n.dwell = 0;
    end else if (m.st == last) begin
      n.st = last;
    end else if (m.st > last) begin
      n.st = 0;
    end else if (!stall) begin
      n.dwell = m.dwell + 1;
      if ((n.dwell >= CFG_HOLD[idx]) && ((CFG_ACK[idx] == 0) || ack)) begin
        n.st    = m.st + 1;
        n.dwell = 0;
      end
    end
    if ((n.st == last) && (m.st != last)) begin
      n.done = 1'b1;
      if (n.count < 255) n.count = n.count + 1;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      mdl[i] = model_next(mdl[i], i, drvEn[i], drvStall[i], drvAck[i], drvSrst[i]);
    end
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N_DUT; i++) begin
      drvEn[i]    = 1'b0;
      drvStall[i] = 1'b0;
      drvAck[i]   = 1'b0;
      drvSrst[i]  = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    #7;
    for (int i = 0; i < N_DUT; i++) mdl[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #12;
    for (int i = 0; i < N_DUT; i++) begin
      mdl[i] = '0;
      checks++;
      if (obsState[i] !== 0) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d: got %0d expected 0", i, obsState[i]);
      end
      checks++;
      if (obsOnehot[i] !== 32'd1) begin
        errors++;
        $display("[TB] FAIL reset_onehot dut%0d: got %0h expected 1", i, obsOnehot[i]);
      end
      checks++;
      if ((obsNormal[i] !== 1'b0) || (obsDone[i] !== 1'b0) || (obsCount[i] !== 0)) begin
        errors++;
        $display("[TB] FAIL reset_status dut%0d: got normal=%b done=%b count=%0d expected 0/0/0",
                 i, obsNormal[i], obsDone[i], obsCount[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_default_boot();
    int expState [5] = '{0, 1, 2, 3, 3};
    apply_reset();
    drvEn[0] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if ((obsState[0] !== expState[e]) || (obsOnehot[0] !== (32'd1 << expState[e]))) begin
        errors++;
        $display("[TB] FAIL default_state edge%0d: got %0d/%0h expected %0d/%0h", e,
                 obsState[0], obsOnehot[0], expState[e], 32'd1 << expState[e]);
      end
      checks++;
      if ((obsDone[0] !== (e == 3)) || (obsNormal[0] !== (e >= 3))) begin
        errors++;
        $display("[TB] FAIL default_done edge%0d: got done=%b normal=%b expected %b/%b", e,
                 obsDone[0], obsNormal[0], e == 3, e >= 3);
      end
    end
    checks++;
    if (obsCount[0] !== 1) begin
      errors++;
      $display("[TB] FAIL default_count: got %0d expected 1", obsCount[0]);
    end
  endtask

  task automatic test_long_hold();
    int expSt;
    apply_reset();
    drvEn[1] = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      step();
      expSt = (e >= 10) ? 4 : 1 + (e - 1) / 3;
      checks++;
      if (obsState[1] !== expSt) begin
        errors++;
        $display("[TB] FAIL hold_state edge%0d: got %0d expected %0d", e, obsState[1], expSt);
      end
      checks++;
      if (obsDone[1] !== (e == 10)) begin
        errors++;
        $display("[TB] FAIL hold_done edge%0d: got %b expected %b", e, obsDone[1], e == 10);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    drvEn[1] = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      drvStall[1] = (e >= 6) && (e <= 9);
      step();
      checks++;
      if (obsState[1] !== mdl[1].st) begin
        errors++;
        $display("[TB] FAIL stall_state edge%0d: got %0d expected %0d", e, obsState[1], mdl[1].st);
      end
      checks++;
      if (obsDone[1] !== (e == 14)) begin
        errors++;
        $display("[TB] FAIL stall_done edge%0d: got %b expected %b", e, obsDone[1], e == 14);
      end
    end
    drvStall[1] = 1'b0;
  endtask

  task automatic test_ack();
    int expState [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 3};
    apply_reset();
    drvEn[2] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      drvAck[2] = (e <= 2) || (e >= 8);
      step();
      checks++;
      if ((obsState[2] !== expState[e]) || (obsDone[2] !== (e == 10))) begin
        errors++;
        $display("[TB] FAIL ack_state edge%0d: got %0d done=%b expected %0d done=%b", e,
                 obsState[2], obsDone[2], expState[e], e == 10);
      end
    end
    drvAck[2] = 1'b0;
  endtask

  task automatic test_soft_rst();
    int expCount;
    apply_reset();
    drvEn[0] = 1'b1;
    step();
    drvSrst[0] = 1'b1;
    step();
    drvSrst[0] = 1'b0;
    checks++;
    if ((obsState[0] !== 0) || (obsDone[0] !== 1'b0) || (obsCount[0] !== 0)) begin
      errors++;
      $display("[TB] FAIL srst_stage1: got state=%0d done=%b count=%0d expected 0/0/0",
               obsState[0], obsDone[0], obsCount[0]);
    end
    for (int b = 1; b <= 300; b++) begin
      expCount = (b < 255) ? b : 255;
      repeat (3) step();
      checks++;
      if ((obsState[0] !== 3) || (obsDone[0] !== 1'b1) || (obsCount[0] !== expCount)) begin
        errors++;
        $display("[TB] FAIL srst_boot%0d: got state=%0d done=%b count=%0d expected 3/1/%0d",
                 b, obsState[0], obsDone[0], obsCount[0], expCount);
      end
      drvSrst[0] = 1'b1;
      step();
      drvSrst[0] = 1'b0;
      checks++;
      if ((obsState[0] !== 0) || (obsDone[0] !== 1'b0) || (obsCount[0] !== expCount)) begin
        errors++;
        $display("[TB] FAIL srst_normal%0d: got state=%0d done=%b count=%0d expected 0/0/%0d",
                 b, obsState[0], obsDone[0], obsCount[0], expCount);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drvEn[0] = 1'b1;
    drvEn[1] = 1'b1;
    repeat (5) step();
    checks++;
    if ((obsCount[0] !== 1) || (obsState[1] !== 2)) begin
      errors++;
      $display("[TB] FAIL arst_setup: got countA=%0d stateB=%0d expected 1/2",
               obsCount[0], obsState[1]);
    end
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ((obsState[i] !== 0) || (obsOnehot[i] !== 32'd1) || (obsNormal[i] !== 1'b0) ||
          (obsDone[i] !== 1'b0) || (obsCount[i] !== 0)) begin
        errors++;
        $display("[TB] FAIL arst_values dut%0d: got state=%0d onehot=%0h normal=%b done=%b count=%0d expected 0/1/0/0/0",
                 i, obsState[i], obsOnehot[i], obsNormal[i], obsDone[i], obsCount[i]);
      end
    end
    clear_inputs();
    for (int i = 0; i < N_DUT; i++) mdl[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      for (int i = 0; i < N_DUT; i++) begin
        checks++;
        if (obsState[i] !== 0) begin
          errors++;
          $display("[TB] FAIL arst_idle dut%0d edge%0d: got %0d expected 0", i, e, obsState[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_DUT; i++) begin
        drvEn[i]    = ($urandom_range(0, 3) != 0);
        drvStall[i] = ($urandom_range(0, 3) == 0);
        drvAck[i]   = ($urandom_range(0, 1) == 1);
        drvSrst[i]  = ($urandom_range(0, 39) == 0);
      end
      step();
      for (int i = 0; i < N_DUT; i++) begin
        checks++;
        if ((obsState[i] !== mdl[i].st) || (obsOnehot[i] !== (32'd1 << mdl[i].st)) ||
            (obsNormal[i] !== (mdl[i].st == CFG_NS[i] - 1))) begin
          errors++;
          $display("[TB] FAIL rand_state dut%0d cyc%0d: got %0d/%0h/%b expected %0d", i, c,
                   obsState[i], obsOnehot[i], obsNormal[i], mdl[i].st);
        end
        checks++;
        if ((obsDone[i] !== mdl[i].done) || (obsCount[i] !== mdl[i].count)) begin
          errors++;
          $display("[TB] FAIL rand_done dut%0d cyc%0d: got done=%b count=%0d expected %b/%0d", i, c,
                   obsDone[i], obsCount[i], mdl[i].done, mdl[i].count);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    $display("[TB] starting boot_sequencer bench");
    test_reset();
    test_default_boot();
    test_long_hold();
    test_stall();
    test_ack();
    test_soft_rst();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
